// File: rtl/camera_pwr_pkg.sv
// Shared camera power state encoding, default timing and per-state output decode,
// used by both the power-on and power-down sequencers.
package camera_pwr_pkg;

  localparam int unsigned CNT_W = 20;

  localparam logic [19:0] T_DRAIN_MAX_DEF = 20'hFFFFF;
  localparam logic [15:0] T_RST_DEF       = 16'hFFFF;
  localparam logic [17:0] T_OFF_MIN_DEF   = 18'h3FFFF;
  localparam logic [15:0] T_WAKE_RST_DEF  = 16'hFFFF;
  localparam logic [19:0] T_SETTLE_DEF    = 20'hFFFFF;

  typedef enum logic [2:0] {
    ST_ON          = 3'd0,
    ST_DRAIN       = 3'd1,
    ST_RST         = 3'd2,
    ST_PWDN        = 3'd3,
    ST_OFF         = 3'd4,
    ST_WAKE_PWDN   = 3'd5,
    ST_WAKE_SETTLE = 3'd6
  } pwr_state_e;

  typedef struct packed {
    logic rstn;
    logic pwnd;
    logic capture_en;
    logic done;
    logic busy;
  } pd_out_t;

  // A state lasting T cycles is loaded with T-1; T=0 behaves as T=1.
  function automatic logic [CNT_W-1:0] load_val(input logic [CNT_W-1:0] t);
    if (t == 20'd0) begin
      return 20'd0;
    end else begin
      return t - 20'd1;
    end
  endfunction

  function automatic pd_out_t state_outputs(input pwr_state_e s);
    pd_out_t o;
    case (s)
      ST_ON:          o = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      ST_DRAIN:       o = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      ST_RST:         o = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      ST_PWDN:        o = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      ST_OFF:         o = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      ST_WAKE_PWDN:   o = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      ST_WAKE_SETTLE: o = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      default:        o = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    endcase
    return o;
  endfunction

endpackage

// File: rtl/seq_timer.sv
// Shared down-counter: loads on request, otherwise counts down and holds at zero.
module seq_timer #(
  parameter int unsigned W = 20
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] value,
  output logic         zero
);

  logic [W-1:0] cnt_d;
  logic [W-1:0] cnt_q;

  // next count: load wins, never wrap below zero
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != {W{1'b0}}) begin
      cnt_d = cnt_q - {{(W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // counter register
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= {W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign value = cnt_q;
  assign zero  = (cnt_q == {W{1'b0}});

endmodule

// File: rtl/camera_power_down_seq.sv
// Camera power-down / wake sequencer: drains the current frame, asserts reset,
// then power-down, and reverses the sequence on wake with settle time.
module camera_power_down_seq #(
  parameter logic [19:0] T_DRAIN_MAX = camera_pwr_pkg::T_DRAIN_MAX_DEF,
  parameter logic [15:0] T_RST       = camera_pwr_pkg::T_RST_DEF,
  parameter logic [17:0] T_OFF_MIN   = camera_pwr_pkg::T_OFF_MIN_DEF,
  parameter logic [15:0] T_WAKE_RST  = camera_pwr_pkg::T_WAKE_RST_DEF,
  parameter logic [19:0] T_SETTLE    = camera_pwr_pkg::T_SETTLE_DEF
) (
  input  logic clk_25M,
  input  logic reset,
  input  logic pd_req,
  input  logic wake_req,
  input  logic frame_busy,
  output logic pd_rstn,
  output logic pd_pwnd,
  output logic capture_en,
  output logic pd_done,
  output logic busy,
  output logic drain_timeout
);

  import camera_pwr_pkg::*;

  pwr_state_e       state_d;
  pwr_state_e       state_q;
  pd_out_t          out_d;
  pd_out_t          out_q;
  logic             drain_timeout_d;
  logic             drain_timeout_q;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_load_val;
  logic [CNT_W-1:0] tmr_value;
  logic             tmr_zero;

  // next-state and sticky timeout; requests outside ON/OFF are simply dropped
  always_comb begin
    state_d         = state_q;
    drain_timeout_d = drain_timeout_q;
    case (state_q)
      ST_ON: begin
        if (pd_req) begin
          state_d         = ST_DRAIN;
          drain_timeout_d = 1'b0;
        end else begin
          state_d = ST_ON;
        end
      end
      ST_DRAIN: begin
        if (!frame_busy) begin
          state_d = ST_RST;
        end else if (tmr_zero) begin
          state_d         = ST_RST;
          drain_timeout_d = 1'b1;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_RST: begin
        if (tmr_zero) state_d = ST_PWDN;
        else          state_d = ST_RST;
      end
      ST_PWDN: begin
        if (tmr_zero) state_d = ST_OFF;
        else          state_d = ST_PWDN;
      end
      ST_OFF: begin
        if (wake_req) state_d = ST_WAKE_PWDN;
        else          state_d = ST_OFF;
      end
      ST_WAKE_PWDN: begin
        if (tmr_zero) state_d = ST_WAKE_SETTLE;
        else          state_d = ST_WAKE_PWDN;
      end
      ST_WAKE_SETTLE: begin
        if (tmr_zero) state_d = ST_ON;
        else          state_d = ST_WAKE_SETTLE;
      end
      default: state_d = ST_ON;
    endcase
  end

  // timer reload on every state change; untimed states park the counter at zero
  always_comb begin
    tmr_load = (state_d != state_q);
    case (state_d)
      ST_DRAIN:       tmr_load_val = load_val(T_DRAIN_MAX);
      ST_RST:         tmr_load_val = load_val({4'd0, T_RST});
      ST_PWDN:        tmr_load_val = load_val({2'd0, T_OFF_MIN});
      ST_WAKE_PWDN:   tmr_load_val = load_val({4'd0, T_WAKE_RST});
      ST_WAKE_SETTLE: tmr_load_val = load_val(T_SETTLE);
      default:        tmr_load_val = 20'd0;
    endcase
  end

  // outputs decode from the next state so they register alongside it
  always_comb begin
    out_d = state_outputs(state_d);
  end

  // state, outputs and timeout flag
  always_ff @(posedge clk_25M) begin
    if (reset) begin
      state_q         <= ST_ON;
      out_q           <= state_outputs(ST_ON);
      drain_timeout_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      out_q           <= out_d;
      drain_timeout_q <= drain_timeout_d;
    end
  end

  seq_timer #(.W(CNT_W)) u_timer (
    .clk      (clk_25M),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .value    (tmr_value),
    .zero     (tmr_zero)
  );

  assign pd_rstn       = out_q.rstn;
  assign pd_pwnd       = out_q.pwnd;
  assign capture_en    = out_q.capture_en;
  assign pd_done       = out_q.done;
  assign busy          = out_q.busy;
  assign drain_timeout = drain_timeout_q;

endmodule

// File: tb/tb_camera_power_down_seq.sv
// Directed-vector bench for camera_power_down_seq with a queue-based scoreboard;
// two instances cover the drain-wait and drain-timeout limits.
module tb_camera_power_down_seq;

  // {pd_rstn, pd_pwnd, capture_en, pd_done, busy, drain_timeout}
  localparam logic [5:0] E_ON = 6'b101000;
  localparam logic [5:0] E_DR = 6'b100010;
  localparam logic [5:0] E_RS = 6'b000010;
  localparam logic [5:0] E_PW = 6'b010010;
  localparam logic [5:0] E_OF = 6'b010100;
  localparam logic [5:0] E_WP = 6'b000010;
  localparam logic [5:0] E_WS = 6'b100010;
  localparam logic [5:0] E_TO = 6'b000001;

  typedef struct {
    int         sel;
    logic [5:0] exp;
    string      tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst_a = 1'b1, pd_a = 1'b0, wk_a = 1'b0, fb_a = 1'b0;
  logic rst_b = 1'b1, pd_b = 1'b0, wk_b = 1'b0, fb_b = 1'b0;
  logic a_rstn, a_pwnd, a_cap, a_done, a_busy, a_to;
  logic b_rstn, b_pwnd, b_cap, b_done, b_busy, b_to;
  logic [5:0] obs_a, obs_b, mon_act;

  exp_t sb_q[$];
  exp_t mon_x;
  int   n_vec = 0;
  int   n_err = 0;

  always #20 clk = ~clk;

  camera_power_down_seq #(
    .T_DRAIN_MAX(20'd32), .T_RST(16'd4), .T_OFF_MIN(18'd4),
    .T_WAKE_RST(16'd4), .T_SETTLE(20'd4)
  ) dut_a (
    .clk_25M(clk), .reset(rst_a), .pd_req(pd_a), .wake_req(wk_a), .frame_busy(fb_a),
    .pd_rstn(a_rstn), .pd_pwnd(a_pwnd), .capture_en(a_cap), .pd_done(a_done),
    .busy(a_busy), .drain_timeout(a_to)
  );

  camera_power_down_seq #(
    .T_DRAIN_MAX(20'd8), .T_RST(16'd4), .T_OFF_MIN(18'd0),
    .T_WAKE_RST(16'd4), .T_SETTLE(20'd4)
  ) dut_b (
    .clk_25M(clk), .reset(rst_b), .pd_req(pd_b), .wake_req(wk_b), .frame_busy(fb_b),
    .pd_rstn(b_rstn), .pd_pwnd(b_pwnd), .capture_en(b_cap), .pd_done(b_done),
    .busy(b_busy), .drain_timeout(b_to)
  );

  assign obs_a = {a_rstn, a_pwnd, a_cap, a_done, a_busy, a_to};
  assign obs_b = {b_rstn, b_pwnd, b_cap, b_done, b_busy, b_to};

  // monitor: one expected entry per clock, compared mid-cycle
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      mon_x   = sb_q.pop_front();
      mon_act = (mon_x.sel == 0) ? obs_a : obs_b;
      n_vec++;
      if (mon_act !== mon_x.exp) begin
        n_err++;
        $display("FAIL %s: dut%0d outputs {rstn,pwnd,cap,done,busy,to} = %b, required %b",
                 mon_x.tag, mon_x.sel, mon_act, mon_x.exp);
      end
    end
  end

  task automatic step(input int sel, input logic r, input logic p, input logic w,
                      input logic f, input logic [5:0] e, input string tag);
    @(negedge clk);
    if (sel == 0) begin
      rst_a = r; pd_a = p; wk_a = w; fb_a = f;
    end else begin
      rst_b = r; pd_b = p; wk_b = w; fb_b = f;
    end
    @(posedge clk);
    #1;
    sb_q.push_back('{sel, e, tag});
  endtask

  task automatic rep(input int sel, input logic p, input logic w, input logic f,
                     input int n, input logic [5:0] e, input string tag);
    for (int i = 0; i < n; i++) step(sel, 1'b0, p, w, f, e, tag);
  endtask

  initial begin
    // instance A: nominal sequence, dropped requests, drain wait, reset abort
    step(0, 1'b1, 1'b0, 1'b0, 1'b0, E_ON, "reset");
    step(0, 1'b1, 1'b1, 1'b1, 1'b0, E_ON, "reset_prio");
    step(0, 1'b0, 1'b0, 1'b1, 1'b0, E_ON, "wake_in_on");
    step(0, 1'b0, 1'b1, 1'b0, 1'b0, E_DR, "pd_cap_off");
    rep (0, 1'b0, 1'b0, 1'b0, 4, E_RS, "drain1_rst");
    step(0, 1'b0, 1'b0, 1'b0, 1'b0, E_PW, "rst4_pwdn");
    step(0, 1'b0, 1'b1, 1'b0, 1'b0, E_PW, "pwdn_pd_drop");
    step(0, 1'b0, 1'b0, 1'b1, 1'b0, E_PW, "pwdn_wake_drop");
    step(0, 1'b0, 1'b1, 1'b1, 1'b0, E_PW, "pwdn_both_drop");
    rep (0, 1'b0, 1'b0, 1'b0, 3, E_OF, "off_hold");
    step(0, 1'b0, 1'b1, 1'b0, 1'b0, E_OF, "off_pd_ign");
    step(0, 1'b0, 1'b0, 1'b1, 1'b0, E_WP, "wake_pwnd0");
    rep (0, 1'b0, 1'b0, 1'b0, 3, E_WP, "wake_pwdn");
    step(0, 1'b0, 1'b0, 1'b0, 1'b0, E_WS, "wake_rstn1");
    step(0, 1'b0, 1'b1, 1'b0, 1'b0, E_WS, "settle_pd_ign");
    rep (0, 1'b0, 1'b0, 1'b0, 2, E_WS, "settle");
    step(0, 1'b0, 1'b0, 1'b0, 1'b0, E_ON, "settle_on");
    step(0, 1'b0, 1'b1, 1'b0, 1'b1, E_DR, "drain_entry");
    rep (0, 1'b0, 1'b0, 1'b1, 10, E_DR, "drain_busy");
    step(0, 1'b0, 1'b0, 1'b0, 1'b0, E_RS, "drain_rst11");
    step(0, 1'b1, 1'b0, 1'b0, 1'b0, E_ON, "reset_in_rst");
    step(0, 1'b0, 1'b1, 1'b1, 1'b0, E_DR, "pd_wake_same");
    step(0, 1'b0, 1'b0, 1'b0, 1'b0, E_RS, "drain_to_rst");

    // instance B: drain timeout, sticky flag, zero-length T_OFF_MIN
    step(1, 1'b1, 1'b0, 1'b0, 1'b0, E_ON, "b_reset");
    step(1, 1'b0, 1'b1, 1'b0, 1'b1, E_DR, "b_drain_entry");
    rep (1, 1'b0, 1'b0, 1'b1, 7, E_DR, "b_drain_busy");
    step(1, 1'b0, 1'b0, 1'b0, 1'b1, E_RS | E_TO, "b_timeout");
    rep (1, 1'b0, 1'b0, 1'b0, 3, E_RS | E_TO, "b_rst");
    step(1, 1'b0, 1'b0, 1'b0, 1'b0, E_PW | E_TO, "b_pwdn");
    step(1, 1'b0, 1'b0, 1'b0, 1'b0, E_OF | E_TO, "b_off_min0");
    step(1, 1'b0, 1'b0, 1'b1, 1'b0, E_WP | E_TO, "b_wake");
    rep (1, 1'b0, 1'b0, 1'b0, 3, E_WP | E_TO, "b_wake_pwdn");
    rep (1, 1'b0, 1'b0, 1'b0, 4, E_WS | E_TO, "b_settle");
    step(1, 1'b0, 1'b0, 1'b0, 1'b0, E_ON | E_TO, "b_to_sticky");
    step(1, 1'b0, 1'b1, 1'b0, 1'b0, E_DR, "b_to_clear");
    step(1, 1'b0, 1'b0, 1'b0, 1'b0, E_RS, "b_drain_rst");

    @(negedge clk);
    #1;
    n_vec++;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
